// File: rtl/core_pkg.sv
// core_pkg: shared core types, fetch FSM encoding and controller constants
package core_pkg;
   localparam int WORD_W = 32;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, EXEC = 2'd2} fetch_state_t;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;
endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: req/ack read port between the fetch unit and instruction memory
interface fetch_unit_if;
   import core_pkg::*;
   logic              imem_req;
   logic [WORD_W-1:0] imem_addr;
   logic              imem_ack;
   logic [WORD_W-1:0] imem_rdata;
   modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
   modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/next_pc_calc.sv
// next_pc_calc: redirect target selection (jr, j/jal, branch, sequential); Jump is active-low
module next_pc_calc
   import core_pkg::*;
(
   input  logic [WORD_W-1:0] pc_plus4,
   input  logic [WORD_W-1:0] instr,
   input  logic [WORD_W-1:0] rs_data,
   input  logic              Jump,
   input  logic              Branch,
   output logic [WORD_W-1:0] next_pc
);
   logic [WORD_W-1:0] br_off;
   assign br_off = {{14{instr[15]}}, instr[15:0], 2'b00};
   assign next_pc = !Jump ? (instr[31:26] == OP_RTYPE ? rs_data & ~32'h3
                                                      : {pc_plus4[31:28], instr[25:0], 2'b00})
                  : Branch ? pc_plus4 + br_off
                  : pc_plus4;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns PC and IR, fetches over a req/ack port, commits one instruction per EXEC.
// Define BRANCH_DELAY_SLOT_EN to defer taken redirects by one instruction (delay slot).
module fetch_unit
   import core_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC = 32'h0000_0000,
   parameter int                CNT_W    = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   fetch_unit_if.master      imem,
   input  logic              stall,
   input  logic              Jump,
   input  logic              Branch,
   input  logic [WORD_W-1:0] rs_data,
   output logic [WORD_W-1:0] instr,
   output logic [5:0]        op,
   output logic [5:0]        func,
   output logic [WORD_W-1:0] pc,
   output logic [WORD_W-1:0] pc_plus4,
   output logic              instr_valid,
   output logic [CNT_W-1:0]  instr_count
);
   fetch_state_t state, state_n;
   logic [WORD_W-1:0] target, commit_pc;
   logic commit;
   assign op = instr[31:26];
   assign func = instr[5:0];
   assign pc_plus4 = pc + 32'd4;
   assign imem.imem_addr = pc;
   next_pc_calc u_npc (
      .pc_plus4 (pc_plus4),
      .instr    (instr),
      .rs_data  (rs_data),
      .Jump     (Jump),
      .Branch   (Branch),
      .next_pc  (target)
   );
   always_comb begin
      state_n = state;
      imem.imem_req = 1'b0;
      instr_valid = 1'b0;
      commit = 1'b0;
      state_n = state == IDLE  ? FETCH
              : state == FETCH ? (imem.imem_ack ? EXEC : FETCH)
              : state == EXEC  ? (stall ? EXEC : FETCH)
              : IDLE;
      imem.imem_req = state == FETCH;
      instr_valid = state == EXEC;
      commit = instr_valid && !stall;
   end
`ifdef BRANCH_DELAY_SLOT_EN
   logic pend;
   logic [WORD_W-1:0] pend_pc;
   // the delay-slot instruction always steps to the stored target, ignoring its own redirect
   assign commit_pc = pend ? pend_pc : pc_plus4;
   always_ff @(posedge clk)
      if (!rst_n) begin
         pend <= 1'b0;
         pend_pc <= '0;
      end else if (commit) begin
         pend <= !pend && (!Jump || Branch);
         pend_pc <= target;
      end
`else
   assign commit_pc = target;
`endif
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         pc <= RESET_PC;
         instr <= '0;
         instr_count <= '0;
      end else begin
         state <= state_n;
         if (state == FETCH && imem.imem_ack) instr <= imem.imem_rdata;
         if (commit) begin
            pc <= commit_pc;
            instr_count <= instr_count + CNT_W'(1);
         end
      end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed plan tests plus randomized run, checked every cycle against a behavioural model
module tb_fetch_unit;
   import core_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   logic Jump = 1'b1;
   logic Branch = 1'b0;
   logic [31:0] rs_data = '0;
   logic [31:0] instr, pc, pc_plus4, instr_count;
   logic [5:0] op, func;
   logic instr_valid;
   fetch_unit_if imem();
   fetch_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (imem),
      .stall       (stall),
      .Jump        (Jump),
      .Branch      (Branch),
      .rs_data     (rs_data),
      .instr       (instr),
      .op          (op),
      .func        (func),
      .pc          (pc),
      .pc_plus4    (pc_plus4),
      .instr_valid (instr_valid),
      .instr_count (instr_count)
   );
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int lat = 3;
   int wcnt = 0;
   bit stray = 1'b0;
   bit chk_en = 1'b0;
   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] memw(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : a * 32'h9E37_79B9 + 32'h1357_2468;
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
      end
   endtask

   // memory responder: acks after lat waiting cycles; optionally drives stray acks while req is low
   initial begin
      imem.imem_ack = 1'b0;
      imem.imem_rdata = '0;
      forever begin
         @(posedge clk);
         #2;
         if (imem.imem_req === 1'b1) begin
            if (wcnt >= lat) begin
               imem.imem_ack = 1'b1;
               imem.imem_rdata = memw(imem.imem_addr);
               wcnt = 0;
            end else begin
               imem.imem_ack = 1'b0;
               imem.imem_rdata = $urandom;
               wcnt++;
            end
         end else begin
            imem.imem_ack = stray;
            imem.imem_rdata = $urandom;
            wcnt = 0;
         end
      end
   end

   // behavioural model: phase 0 idle, 1 fetching, 2 executing
   int m_ph = 0;
   logic [31:0] m_pc = '0, m_instr = '0, m_cnt = '0, m_tgt = '0, m_p4, m_t;
   bit m_pend = 1'b0;
   always @(negedge clk) if (chk_en) begin
      chk("req", 32'(imem.imem_req), 32'(m_ph == 1));
      if (m_ph == 1) chk("addr", imem.imem_addr, m_pc);
      chk("valid", 32'(instr_valid), 32'(m_ph == 2));
      chk("pc", pc, m_pc);
      chk("instr", instr, m_instr);
      chk("op", 32'(op), 32'(m_instr[31:26]));
      chk("func", 32'(func), 32'(m_instr[5:0]));
      chk("pc_plus4", pc_plus4, m_pc + 32'd4);
      chk("count", instr_count, m_cnt);
      if (!rst_n) begin
         m_ph = 0; m_pc = '0; m_instr = '0; m_cnt = '0; m_pend = 1'b0;
      end else if (m_ph == 0) begin
         m_ph = 1;
      end else if (m_ph == 1) begin
         if (imem.imem_ack) begin
            m_instr = imem.imem_rdata;
            m_ph = 2;
         end
      end else if (!stall) begin
         m_p4 = m_pc + 32'd4;
         if (!Jump) m_t = m_instr[31:26] == 6'd0 ? rs_data & 32'hFFFF_FFFC : {m_p4[31:28], m_instr[25:0], 2'b00};
         else if (Branch) m_t = m_p4 + 32'($signed(m_instr[15:0])) * 32'd4;
         else m_t = m_p4;
`ifdef BRANCH_DELAY_SLOT_EN
         if (m_pend) begin
            m_pc = m_tgt;
            m_pend = 1'b0;
         end else begin
            if (!Jump || Branch) begin
               m_tgt = m_t;
               m_pend = 1'b1;
            end
            m_pc = m_p4;
         end
`else
         m_pc = m_t;
`endif
         m_cnt = m_cnt + 32'd1;
         m_ph = 1;
      end
   end

   task automatic wait_valid();
      int n = 0;
      @(negedge clk);
      while (instr_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk("valid_wait", 32'(instr_valid), 32'd1);
   endtask

   task automatic exec_one(input logic j, input logic b, input logic [31:0] rs, input logic [31:0] epc, input logic [31:0] ei);
      Jump = j;
      Branch = b;
      rs_data = rs;
      wait_valid();
      chk("exec_pc", pc, epc);
      chk("exec_instr", instr, ei);
      chk("exec_link", pc_plus4, epc + 32'd4);
      @(posedge clk);
      #2;
      Jump = 1'b1;
      Branch = 1'b0;
   endtask

   initial begin
      mem[32'h0000_0000] = 32'h2002_0005;
      mem[32'h0000_0004] = 32'h1000_0003;
      mem[32'h0000_0008] = 32'h0800_0010;
      mem[32'h0000_0014] = 32'h03E0_0008;
      mem[32'h0000_003C] = 32'h03E0_0008;
      mem[32'h0000_0040] = 32'h1000_FFFE;
      mem[32'h1000_0000] = 32'h0C00_0100;
      mem[32'h1000_0400] = 32'h0200_0008;
      repeat (2) @(posedge clk);
      #2;
      chk_en = 1'b1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_req", 32'(imem.imem_req), 32'd0);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_count", instr_count, 32'h0);
      @(negedge clk);
      chk("t1_req", 32'(imem.imem_req), 32'd1);
      chk("t1_addr", imem.imem_addr, 32'h0);
      wait_valid();
      chk("t1_instr", instr, 32'h2002_0005);
      chk("t1_pc", pc, 32'h0);
      @(negedge clk);
      chk("t1_valid_once", 32'(instr_valid), 32'd0);
      chk("t1_pc_next", pc, 32'h4);
      chk("t1_count", instr_count, 32'd1);
      @(posedge clk);
      #2;
      stall = 1'b1;
      wait_valid();
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #2;
         Branch = i[0];
         @(negedge clk);
         chk("t2_hold_valid", 32'(instr_valid), 32'd1);
         chk("t2_hold_pc", pc, 32'h4);
         chk("t2_hold_instr", instr, 32'h1000_0003);
         chk("t2_hold_count", instr_count, 32'd1);
      end
      @(posedge clk);
      #2;
      stall = 1'b0;
      Branch = 1'b0;
      @(negedge clk);
      chk("t2_release_valid", 32'(instr_valid), 32'd1);
      @(negedge clk);
      chk("t2_pc", pc, 32'h8);
      chk("t2_count", instr_count, 32'd2);
      lat = 0;
      @(posedge clk);
      #2;
      exec_one(1'b0, 1'b0, 32'h0, 32'h8, 32'h0800_0010);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b0, 1'b1, 32'hDEAD_BEE0, 32'hC, memw(32'hC));
`endif
      exec_one(1'b1, 1'b1, 32'h0, 32'h40, 32'h1000_FFFE);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b1, 1'b0, 32'h0, 32'h44, memw(32'h44));
`endif
      exec_one(1'b0, 1'b0, 32'h1000_0000, 32'h3C, 32'h03E0_0008);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b1, 1'b0, 32'h0, 32'h40, 32'h1000_FFFE);
`endif
      exec_one(1'b0, 1'b0, 32'h0, 32'h1000_0000, 32'h0C00_0100);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b1, 1'b0, 32'h0, 32'h1000_0004, memw(32'h1000_0004));
`endif
      exec_one(1'b0, 1'b0, 32'h0000_1237, 32'h1000_0400, 32'h0200_0008);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b1, 1'b0, 32'h0, 32'h1000_0404, memw(32'h1000_0404));
`endif
      rst_n = 1'b0;
      stray = 1'b1;
      @(negedge clk);
      chk("t5_addr", imem.imem_addr, 32'h0000_1234);
      chk("t5_req", 32'(imem.imem_req), 32'd1);
      @(negedge clk);
      chk("t5_req_drop", 32'(imem.imem_req), 32'd0);
      chk("t5_instr", instr, 32'h0);
      chk("t5_pc", pc, 32'h0);
      chk("t5_count", instr_count, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      chk("t5_idle_req", 32'(imem.imem_req), 32'd0);
      @(negedge clk);
      chk("t5_refetch_addr", imem.imem_addr, 32'h0);
      chk("t5_refetch_req", 32'(imem.imem_req), 32'd1);
      chk("t5_stray_ignored", instr, 32'h0);
      @(posedge clk);
      #2;
      stray = 1'b0;
      exec_one(1'b1, 1'b0, 32'h0, 32'h0, 32'h2002_0005);
      exec_one(1'b1, 1'b1, 32'h0, 32'h4, 32'h1000_0003);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b1, 1'b0, 32'h0, 32'h8, 32'h0800_0010);
`endif
      exec_one(1'b0, 1'b0, 32'hFFFF_FFFF, 32'h14, 32'h03E0_0008);
`ifdef BRANCH_DELAY_SLOT_EN
      exec_one(1'b1, 1'b0, 32'h0, 32'h18, memw(32'h18));
`endif
      exec_one(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC, memw(32'hFFFF_FFFC));
      wait_valid();
      chk("wrap_pc", pc, 32'h0);
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         stall = $urandom_range(0, 3) == 0;
         Jump = $urandom_range(0, 6) != 0;
         Branch = $urandom_range(0, 3) == 0;
         rs_data = $urandom;
         lat = $urandom_range(0, 3);
         stray = $urandom_range(0, 1) == 1;
         rst_n = $urandom_range(0, 199) != 0;
      end
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream fetch stage for the single-cycle MIPS core.
- Owns the program counter and the instruction register, and runs a req/ack handshake to a multi-cycle instruction memory.
- Presents op/func to the instruction controller and the full instruction word to the datapath for one EXEC cycle.
- Consumes the controller's Branch and Jump outputs to form the next PC. Jump is active-low: 0 means jump.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
CNT_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  core clock; all state changes on the rising edge.
rst_n  in  1  synchronous, active-low reset.
imem_req  out  1  instruction memory read request.
imem_addr  out  32  word-aligned fetch address.
imem_ack  in  1  memory data valid; sampled only in FETCH.
imem_rdata  in  32  instruction word; valid when imem_ack=1.
stall  in  1  datapath hold; extends EXEC.
Jump  in  1  from controller, active-low.
Branch  in  1  from controller, active-high (already zero-qualified).
rs_data  in  32  register-file rs value; the jr target.
instr  out  32  instruction register.
op  out  6  instr[31:26].
func  out  6  instr[5:0].
pc  out  32  address of the instruction in instr.
pc_plus4  out  32  pc+4; also the jal link value.
instr_valid  out  1  instr is executing this cycle.
instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (rst_n=0 at an edge), from any state:
  - State goes to IDLE; pc=RESET_PC; instr=0; imem_req=0; instr_valid=0; instr_count=0; pending delay-slot state cleared.
  - A reset during FETCH drops imem_req on that edge.
  - A late imem_ack seen in IDLE is ignored.
- States:
  - IDLE: one cycle after reset deasserts. Outputs quiet. Moves to FETCH.
  - FETCH: imem_req=1, imem_addr=pc. Holds until imem_ack=1. On the ack edge, instr<=imem_rdata and state moves to EXEC. A zero-wait ack (same cycle as req) is legal, giving a 2-cycle instruction.
  - EXEC: instr_valid=1, imem_req=0.
    - If stall=1, stay in EXEC; pc, instr and instr_count hold; Jump and Branch are ignored.
    - If stall=0, commit on this edge: pc<=next_pc, instr_count<=instr_count+1 (wraps at 2^CNT_W), state moves to FETCH.
- next_pc, priority highest first:
  - Jump=0 and op==0 (jr): {rs_data[31:2],2'b00}. Misaligned bits are silently dropped.
  - Jump=0 and op!=0 (j/jal): {pc_plus4[31:28], instr[25:0], 2'b00}.
  - Branch=1: pc_plus4 + (sign_extend(instr[15:0]) << 2).
  - Otherwise: pc_plus4.
- Arithmetic is modulo 2^32; PC wrap from 32'hFFFF_FFFC to 0 is legal.
- op, func and pc_plus4 are combinational from instr and pc.

Optional Feature:
- Macro: BRANCH_DELAY_SLOT_EN.
- Defined:
  - A taken Jump or Branch at commit stores the target in a pending register and sets pending=1; pc<=pc_plus4.
  - The next committed instruction (the delay slot) uses the pending target as next_pc, regardless of its own Jump/Branch, and clears pending.
  - instr_count increments normally.
- Undefined: redirect takes effect at the same commit; no pending register is synthesised.

Decomposition:
- Shared package core_pkg holds:
  - FSM state encoding: IDLE=2'd0, FETCH=2'd1, EXEC=2'd2.
  - OP_RTYPE=6'b000000.
  - WORD_W=32.
  - The ALU code constants shared with the controller.
- One sub-module, next_pc_calc (purely combinational): pc_plus4, instr, rs_data, Jump, Branch in; next_pc out.

Test Plan:
1. Reset, then ack with 3-cycle latency returning 32'h2002_0005 -> imem_addr=0; instr_valid high one cycle; pc goes 0 to 4; instr_count=1.
2. EXEC with stall=1 for 4 cycles, Branch toggling -> pc, instr and instr_count frozen; commit uses Branch sampled on the release cycle only.
3. pc=32'h0000_0040, beq instr imm=16'hFFFE, Branch=1 -> next fetch address 32'h0000_003C.
4. pc=32'h1000_0000, jal target 26'h000_0100 with Jump=0 -> 32'h1000_0400; jr with rs_data=32'h0000_1237 -> 32'h0000_1234.
5. rst_n low mid-FETCH, ack arriving the same cycle -> instr stays 0; req drops; refetch starts at RESET_PC.
6. With BRANCH_DELAY_SLOT_EN, taken j at pc=8 -> instruction at 12 executes before the target; without it, the target is fetched directly after 8.
